// File: rtl/rr_arb3_ctrl_if.sv
// Requester/resource bundle for the three-way round-robin arbiter.
// The master side owns req/payloads/ready; the slave side (the arbiter) drives grant and transfer.
interface rr_arb3_ctrl_if #(
    parameter int DW = 4
);
    logic [2:0]    req;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic          res_ready;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [2:0]    gnt;
    logic          busy;

    modport master (
        output req, data0, data1, data2, res_ready,
        input  res_valid, res_data, gnt, busy
    );

    modport slave (
        input  req, data0, data1, data2, res_ready,
        output res_valid, res_data, gnt, busy
    );
endinterface

// File: rtl/rr_arb3_ctrl.sv
// Three-requester round-robin arbiter with burst-capped tenures.
// One grant at a time; the owner's payload is offered over res_valid/res_ready.
module rr_arb3_ctrl #(
    parameter int DW        = 4,
    parameter int MAX_BURST = 4,
    parameter int CW        = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arb3_ctrl_if.slave  bus
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_GRANT = 1'b1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    // Index (p + off) mod 3, for p and off both in 0..2.
    function automatic logic [1:0] add_mod3(input logic [1:0] p, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, p} + {1'b0, off};
        if (sum >= 3'd3) begin
            add_mod3 = 2'(sum - 3'd3);
        end else begin
            add_mod3 = sum[1:0];
        end
    endfunction

    // Returns {hit, idx}: first set request searching p, p+1, p+2 (mod 3).
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] rot;
        logic [1:0] off;
        logic       hit;
        case (p)
            2'd0:    rot = r;
            2'd1:    rot = {r[0], r[2], r[1]};
            2'd2:    rot = {r[1], r[0], r[2]};
            default: rot = r;
        endcase
        hit = 1'b1;
        if (rot[0]) begin
            off = 2'd0;
        end else if (rot[1]) begin
            off = 2'd1;
        end else if (rot[2]) begin
            off = 2'd2;
        end else begin
            off = 2'd0;
            hit = 1'b0;
        end
        rr_pick = {hit, add_mod3(p, off)};
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot3 = 3'b001;
            2'd1:    onehot3 = 3'b010;
            2'd2:    onehot3 = 3'b100;
            default: onehot3 = 3'b000;
        endcase
    endfunction

    logic [0:0]    state_r;
    logic [2:0]    gnt_r;
    logic [1:0]    owner_r;
    logic [1:0]    ptr_r;
    logic [CW-1:0] cnt_r;

    logic          owner_req_s;
    logic [DW-1:0] owner_data_s;
    logic          valid_s;
    logic          xfer_s;
    logic          release_s;
    logic [2:0]    pick_s;
    logic [1:0]    ptr_next_s;

    // Owner's request line and payload, selected by the registered owner index.
    always_comb begin
        owner_req_s  = 1'b0;
        owner_data_s = {DW{1'b0}};
        case (owner_r)
            2'd0: begin
                owner_req_s  = bus.req[0];
                owner_data_s = bus.data0;
            end
            2'd1: begin
                owner_req_s  = bus.req[1];
                owner_data_s = bus.data1;
            end
            2'd2: begin
                owner_req_s  = bus.req[2];
                owner_data_s = bus.data2;
            end
            default: begin
                owner_req_s  = 1'b0;
                owner_data_s = {DW{1'b0}};
            end
        endcase
    end

    // Transfer qualification and tenure release; valid is gated by the live req so a dropping owner sees no transfer.
    always_comb begin
        valid_s    = (state_r == ST_GRANT) && ((gnt_r & bus.req) != 3'b000);
        xfer_s     = valid_s && bus.res_ready;
        release_s  = 1'b0;
        if (state_r == ST_GRANT) begin
            release_s = !owner_req_s || (xfer_s && (cnt_r == LAST_CNT));
        end else begin
            release_s = 1'b0;
        end
        pick_s     = rr_pick(bus.req, ptr_r);
        ptr_next_s = add_mod3(owner_r, 2'd1);
    end

    // Arbitration state, grant, owner, pointer and burst counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 3'b000;
            owner_r <= 2'd0;
            ptr_r   <= 2'd0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_s[2]) begin
                        gnt_r   <= onehot3(pick_s[1:0]);
                        owner_r <= pick_s[1:0];
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_GRANT;
                    end else begin
                        gnt_r   <= 3'b000;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        gnt_r   <= 3'b000;
                        cnt_r   <= {CW{1'b0}};
                        ptr_r   <= ptr_next_s;
                        state_r <= ST_IDLE;
                    end else if (xfer_s) begin
                        cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 3'b000;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.res_valid = valid_s;
    assign bus.res_data  = valid_s ? owner_data_s : {DW{1'b0}};
    assign bus.gnt       = gnt_r;
    assign bus.busy      = (state_r == ST_GRANT);

endmodule

// File: tb/tb_rr_arb3_ctrl.sv
// Bench for rr_arb3_ctrl: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a tenure-level reference model.
module tb_rr_arb3_ctrl;

    localparam int MB = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   fails;

    rr_arb3_ctrl_if #(.DW(4)) bus ();

    rr_arb3_ctrl #(.DW(4), .MAX_BURST(MB), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who holds the resource, how many transfers so far, where the search starts.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;

    logic [2:0] s_gnt;
    logic       s_valid;
    logic       s_busy;
    logic [3:0] s_data;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] owner_data(input int o);
        if (o == 0) return bus.data0;
        if (o == 1) return bus.data1;
        return bus.data2;
    endfunction

    // One clock: compare at negedge with inputs already applied, then advance the model at posedge.
    task automatic step(input bit check_en);
        bit         ev;
        logic [3:0] ed;
        logic [2:0] eg;
        @(negedge clk);
        s_gnt   = bus.gnt;
        s_valid = bus.res_valid;
        s_busy  = bus.busy;
        s_data  = bus.res_data;
        ev = m_busy && bus.req[m_owner];
        ed = ev ? owner_data(m_owner) : 4'h0;
        eg = m_busy ? 3'(1 << m_owner) : 3'b000;
        if (check_en) begin
            chk("gnt",       {5'd0, s_gnt},   {5'd0, eg});
            chk("res_valid", {7'd0, s_valid}, {7'd0, ev});
            chk("busy",      {7'd0, s_busy},  {7'd0, m_busy});
            chk("res_data",  {4'd0, s_data},  {4'd0, ed});
        end
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            for (int i = 0; i < 3; i++) begin
                if (!m_busy && bus.req[(m_ptr + i) % 3]) begin
                    m_busy  = 1'b1;
                    m_owner = (m_ptr + i) % 3;
                    m_cnt   = 0;
                end
            end
        end else begin
            bit rel;
            rel = 1'b0;
            if (!bus.req[m_owner]) begin
                rel = 1'b1;
            end else if (bus.res_ready) begin
                m_cnt++;
                if (m_cnt == MB) rel = 1'b1;
            end
            if (rel) begin
                m_busy = 1'b0; m_cnt = 0; m_ptr = (m_owner + 1) % 3;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        bus.req = 3'b000;
        for (int i = 0; i < n; i++) step(1'b1);
        rst_n = 1'b1;
    endtask

    logic [2:0] seq_g [0:16];
    logic [3:0] seq_d [0:16];
    logic [2:0] exp_g [0:16];
    logic [3:0] exp_d [0:16];
    int         granted;

    initial begin
        vectors = 0; fails = 0;
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        rst_n = 1'b0;
        bus.req = 3'b000; bus.res_ready = 1'b0;
        bus.data0 = 4'h1; bus.data1 = 4'h2; bus.data2 = 4'h3;
        #1;
        step(1'b0);
        do_reset(2);
        chk("reset_gnt",   {5'd0, s_gnt},   8'h00);
        chk("reset_busy",  {7'd0, s_busy},  8'h00);
        chk("reset_valid", {7'd0, s_valid}, 8'h00);
        chk("reset_data",  {4'd0, s_data},  8'h00);

        // Three full tenures, round-robin with ptr wrap back to requester 0.
        exp_g = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010,
                  3'b010, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
        exp_d = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                  4'h2, 4'h0, 4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h1};
        bus.req = 3'b111; bus.res_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(1'b1);
            seq_g[i] = s_gnt;
            seq_d[i] = s_data;
        end
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("rr_seq_gnt[%0d]", i),  {5'd0, seq_g[i]}, {5'd0, exp_g[i]});
            chk($sformatf("rr_seq_data[%0d]", i), {4'd0, seq_d[i]}, {4'd0, exp_d[i]});
        end

        // Single requester with ready toggling: 4 accepts take 7 granted cycles.
        do_reset(1);
        bus.req = 3'b010;
        granted = 0;
        for (int k = 0; k < 10; k++) begin
            bus.res_ready = (k % 2 == 1);
            step(1'b1);
            seq_g[k] = s_gnt;
            if (k >= 1 && k <= 8 && s_gnt == 3'b010) granted++;
        end
        chk("toggle_tenure_len", 8'(granted), 8'd7);
        chk("toggle_dead_cycle", {5'd0, seq_g[8]}, 8'h00);
        chk("toggle_regrant",    {5'd0, seq_g[9]}, 8'h02);

        // Owner 0 drops after two transfers; next search starts at 1.
        do_reset(1);
        bus.data0 = 4'h5; bus.res_ready = 1'b1;
        bus.req = 3'b001;
        for (int k = 0; k < 3; k++) step(1'b1);
        bus.req = 3'b100;
        step(1'b1);
        chk("drop_valid", {7'd0, s_valid}, 8'h00);
        chk("drop_gnt",   {5'd0, s_gnt},   8'h01);
        bus.req = 3'b101;
        step(1'b1);
        chk("drop_release", {5'd0, s_gnt}, 8'h00);
        step(1'b1);
        chk("drop_next_gnt", {5'd0, s_gnt}, 8'h04);

        // Reset in mid-tenure with two transfers done.
        do_reset(1);
        bus.req = 3'b111;
        for (int k = 0; k < 3; k++) step(1'b1);
        rst_n = 1'b0;
        step(1'b1);
        rst_n = 1'b1;
        bus.req = 3'b110;
        step(1'b1);
        chk("midrst_gnt",   {5'd0, s_gnt},   8'h00);
        chk("midrst_busy",  {7'd0, s_busy},  8'h00);
        chk("midrst_valid", {7'd0, s_valid}, 8'h00);
        step(1'b1);
        chk("midrst_next_gnt", {5'd0, s_gnt}, 8'h02);

        // Long idle with no requests.
        do_reset(1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1);
            chk("idle_gnt",   {5'd0, s_gnt},   8'h00);
            chk("idle_valid", {7'd0, s_valid}, 8'h00);
            chk("idle_busy",  {7'd0, s_busy},  8'h00);
        end

        // Randomized traffic checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            logic [2:0] r;
            r = bus.req;
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            bus.req       = r;
            bus.res_ready = ($urandom_range(0, 3) != 0);
            bus.data0     = 4'($urandom);
            bus.data1     = 4'($urandom);
            bus.data2     = 4'($urandom);
            rst_n         = ($urandom_range(0, 199) != 0);
            step(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/rr_arb3_ctrl.md
Name: rr_arb3_ctrl

Overview:
- Round-robin arbiter/sequencer that shares one downstream resource between three requesters, each with a 4-bit payload.
- Grants one requester at a time and forwards that requester's payload over a valid/ready handshake.
- Caps each tenure at a maximum burst length so no requester can starve the others.
- Sits between the requesting blocks and the shared resource port.

Parameters:
- DW, 4, payload width per requester.
- MAX_BURST, 4, maximum accepted transfers per grant tenure (legal range 1..15).
- CW, 4, burst counter width; must satisfy 2^CW > MAX_BURST.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req  input  3  request per requester; bit k is requester k; held high while requester has data.
- data0  input  DW  payload of requester 0.
- data1  input  DW  payload of requester 1.
- data2  input  DW  payload of requester 2.
- res_ready  input  1  shared resource can accept a transfer this cycle.
- res_valid  output  1  transfer offered to resource.
- res_data  output  DW  payload of current owner.
- gnt  output  3  one-hot grant, registered.
- busy  output  1  high while a grant tenure is active.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (rst_n low at a clk edge): state=IDLE, gnt=3'b000, ptr=0, cnt=0.
  - Consequently res_valid=0, busy=0, res_data=0.
  - Reset mid-tenure aborts the tenure immediately; there is no flush.
- State machine: IDLE, GRANT.
- IDLE:
  - gnt=0.
  - If req!=0, select the first set bit searching ptr, ptr+1, ptr+2 (mod 3).
  - Next cycle: gnt=onehot(sel), owner=sel, cnt=0, state=GRANT.
  - If req==0, remain in IDLE.
- GRANT:
  - res_valid = |(gnt & req); combinational, so a requester dropping req never sees a transfer that cycle.
  - res_data = data of owner when res_valid, else 0.
  - Transfer occurs on a cycle with res_valid && res_ready; cnt increments by 1 on each transfer.
  - Release when either condition holds:
    - (a) req[owner]==0; or
    - (b) a transfer occurs with cnt==MAX_BURST-1.
  - On release, next cycle: gnt=0, cnt=0, ptr=(owner+1) mod 3, state=IDLE.
  - res_ready low: cnt holds and the grant is kept; no timeout.
- Latency:
  - req rising in IDLE at edge N gives gnt at N+1.
  - After release, a cycle in IDLE precedes the next grant: one dead cycle between tenures, always.
- busy = (state==GRANT).
- gnt is always one-hot or zero; never more than one bit set.
- Non-owner req changes during GRANT are ignored until IDLE.
- Simultaneous release conditions (a) and (b): treated as a single release, with ptr advanced once.
- ptr wrap: owner=2 gives ptr=0.
- MAX_BURST=1: release after every accepted transfer.

Test Plan:
- Reset then req=3'b111 steady, res_ready=1, data0=4'h1, data1=4'h2, data2=4'h3 -> gnt sequence 001,000,010,000,100,000,001.
  - Each tenure shows exactly 4 transfers of its data value; busy high for 4 cycles per tenure.
- req=3'b010 only, res_ready toggling 1,0,1,0,... -> gnt=010 held until 4 accepts.
  - cnt frozen on ready-low cycles; release on the 4th accept.
  - Next grant is 010 again after one idle cycle (ptr=2, only req1 set).
- Owner 0 granted, drops req0 after 2 transfers -> res_valid=0 that same cycle, gnt=000 next cycle, ptr=1.
  - If req=3'b101 at that point, next grant is 100.
- Owner 2 granted with req=3'b111 -> after release, ptr wraps to 0 and the next gnt is 001.
- rst_n low for one cycle during GRANT with cnt=2 -> next cycle gnt=0, busy=0, res_valid=0.
  - After reset, req=3'b110 gives gnt=010 (ptr reset to 0, first set bit searching from 0 is bit 1).
- Idle with req=0 for 10 cycles -> gnt, res_valid and busy remain 0; no state change.
